rd_serial_receiver: RTL and testbench

- Receiving end of the RD detector serial link.
- Issues a TRIGGER to the RD side, then waits for ENABLE_XFR.
- Deserialises two parallel lanes: 12 data bits MSB first, then one odd-parity bit per word.
- Writes each received word pair into a buffer/BRAM write port and reports completion and link errors to the PS register block.

---
 rtl/rd_serial_receiver.sv | 173 +++++++++++++++++
 tb/tb_rd_serial_receiver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_serial_receiver.sv
// RD link receiver: 2 lanes of 12-bit words + odd parity, MSB first; each word is written 1 cycle after its parity slot, with no backpressure.
// Parity checking is compiled in only with RD_RX_PARITY_CHECK_EN; otherwise WR_PERR and PERR_COUNT stay 0.
module rd_serial_receiver #(
  parameter int NUM_WORDS  = 2048,
  parameter int ADDR_WIDTH = 11,
  parameter int TRIG_WIDTH = 4,
  parameter int TIMEOUT    = 4095
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  CLR_ERR,
  output logic                  TRIGGER,
  input  logic                  ENABLE_XFR,
  input  logic                  SERIAL_IN0,
  input  logic                  SERIAL_IN1,
  output logic                  WR_EN,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [11:0]           WR_DATA0,
  output logic [11:0]           WR_DATA1,
  output logic [1:0]            WR_PERR,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ADDR_WIDTH:0]   WORD_COUNT,
  output logic [15:0]           PERR_COUNT,
  output logic                  ERR_TIMEOUT,
  output logic                  ERR_SHORT
);

  localparam int TRIG_CW = $clog2(TRIG_WIDTH + 1);
  localparam int WAIT_CW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_XFR, RECV, FLUSH} state_t;

  state_t              state, state_next;
  logic                en_r, s0_r, s1_r;
  logic [11:0]         sh0, sh1;
  logic [3:0]          slot;
  logic [TRIG_CW-1:0]  trig_cnt;
  logic [WAIT_CW-1:0]  wait_cnt;
  logic                shift_en, word_end, set_timeout, set_short, xfer_end;

  always_comb begin
    state_next  = state;
    shift_en    = 1'b0;
    word_end    = 1'b0;
    set_timeout = 1'b0;
    set_short   = 1'b0;
    xfer_end    = 1'b0;
    case (state)
      IDLE:     if (START) state_next = TRIG;
      TRIG:     if (trig_cnt == TRIG_CW'(TRIG_WIDTH - 1)) state_next = WAIT_XFR;
      WAIT_XFR: begin
        // The first enabled cycle already carries D11 of word 0.
        if (en_r) begin
          shift_en   = 1'b1;
          state_next = RECV;
        end else if (wait_cnt == WAIT_CW'(TIMEOUT - 1)) begin
          set_timeout = 1'b1;
          state_next  = IDLE;
        end
      end
      RECV: begin
        if (en_r) begin
          shift_en = 1'b1;
          if (slot == 4'd12) begin
            word_end = 1'b1;
            if (WORD_COUNT == LAST_WORD) state_next = FLUSH;
          end
        end else begin
          set_short  = 1'b1;
          state_next = IDLE;
        end
      end
      FLUSH: begin
        if (!en_r) begin
          xfer_end   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    TRIGGER = (state == TRIG);
    BUSY    = (state != IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      en_r     <= 1'b0;
      s0_r     <= 1'b0;
      s1_r     <= 1'b0;
      sh0      <= '0;
      sh1      <= '0;
      slot     <= '0;
      trig_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      en_r     <= ENABLE_XFR;
      s0_r     <= SERIAL_IN0;
      s1_r     <= SERIAL_IN1;
      trig_cnt <= (state == TRIG) ? trig_cnt + TRIG_CW'(1) : '0;
      wait_cnt <= (state == WAIT_XFR) ? wait_cnt + WAIT_CW'(1) : '0;
      if (state == IDLE)
        slot <= '0;
      else if (shift_en)
        slot <= (slot == 4'd12) ? 4'd0 : slot + 4'd1;
      // The parity bit also shifts in; it is pushed out by the next word's data.
      if (shift_en) begin
        sh0 <= {sh0[10:0], s0_r};
        sh1 <= {sh1[10:0], s1_r};
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WR_EN       <= 1'b0;
      WR_ADDR     <= '0;
      WR_DATA0    <= '0;
      WR_DATA1    <= '0;
      DONE        <= 1'b0;
      WORD_COUNT  <= '0;
      ERR_TIMEOUT <= 1'b0;
      ERR_SHORT   <= 1'b0;
    end else begin
      WR_EN <= word_end;
      DONE  <= set_timeout | set_short | xfer_end;
      if (word_end) begin
        WR_ADDR  <= WORD_COUNT[ADDR_WIDTH-1:0];
        WR_DATA0 <= sh0;
        WR_DATA1 <= sh1;
      end
      if (state == IDLE && START)
        WORD_COUNT <= '0;
      else if (word_end)
        WORD_COUNT <= WORD_COUNT + (ADDR_WIDTH + 1)'(1);
      if (set_timeout)  ERR_TIMEOUT <= 1'b1;
      else if (CLR_ERR) ERR_TIMEOUT <= 1'b0;
      if (set_short)    ERR_SHORT <= 1'b1;
      else if (CLR_ERR) ERR_SHORT <= 1'b0;
    end
  end

`ifdef RD_RX_PARITY_CHECK_EN
  logic [1:0] perr_now;
  logic       perr_word;

  // A lane is good when its 12 data bits plus P hold an odd number of ones.
  assign perr_now  = {~^{sh1, s1_r}, ~^{sh0, s0_r}};
  assign perr_word = word_end & (|perr_now);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WR_PERR    <= 2'b00;
      PERR_COUNT <= '0;
    end else begin
      if (word_end) WR_PERR <= perr_now;
      if (perr_word)
        PERR_COUNT <= CLR_ERR ? 16'd1 :
                      (PERR_COUNT == 16'hFFFF) ? PERR_COUNT : PERR_COUNT + 16'd1;
      else if (CLR_ERR)
        PERR_COUNT <= '0;
    end
  end
`else
  assign WR_PERR    = 2'b00;
  assign PERR_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_rd_serial_receiver.sv
// Directed bench for rd_serial_receiver (NUM_WORDS=4, TIMEOUT=20); expectations follow RD_RX_PARITY_CHECK_EN.
module tb_rd_serial_receiver;
  localparam int NW = 4;
  localparam int AW = 2;
  localparam int TW = 4;
  localparam int TO = 20;
`ifdef RD_RX_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET, START, CLR_ERR, ENABLE_XFR, SERIAL_IN0, SERIAL_IN1;
  logic          TRIGGER, WR_EN, BUSY, DONE, ERR_TIMEOUT, ERR_SHORT;
  logic [AW-1:0] WR_ADDR;
  logic [11:0]   WR_DATA0, WR_DATA1;
  logic [1:0]    WR_PERR;
  logic [AW:0]   WORD_COUNT;
  logic [15:0]   PERR_COUNT;

  rd_serial_receiver #(.NUM_WORDS(NW), .ADDR_WIDTH(AW), .TRIG_WIDTH(TW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .CLR_ERR(CLR_ERR), .TRIGGER(TRIGGER),
    .ENABLE_XFR(ENABLE_XFR), .SERIAL_IN0(SERIAL_IN0), .SERIAL_IN1(SERIAL_IN1),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA0(WR_DATA0), .WR_DATA1(WR_DATA1),
    .WR_PERR(WR_PERR), .BUSY(BUSY), .DONE(DONE), .WORD_COUNT(WORD_COUNT),
    .PERR_COUNT(PERR_COUNT), .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_SHORT(ERR_SHORT)
  );

  always #5 CLK = ~CLK;

  // Word tables with hand-computed odd-parity bits.
  logic [11:0] l0 [4] = '{12'h000, 12'h001, 12'hA5C, 12'hFFF};
  logic        p0 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [11:0] l1 [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
  logic        p1 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  int vec_cnt = 0;
  int miss_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] m_addr [64];
  logic [11:0]   m_d0 [64];
  logic [11:0]   m_d1 [64];
  logic [1:0]    m_perr [64];
  int            n_wr = 0;
  int            n_done = 0;

  always @(negedge CLK) begin
    if (WR_EN && n_wr < 64) begin
      m_addr[n_wr] = WR_ADDR;
      m_d0[n_wr]   = WR_DATA0;
      m_d1[n_wr]   = WR_DATA1;
      m_perr[n_wr] = WR_PERR;
      n_wr++;
    end
    if (DONE) n_done++;
  end

  task automatic start_xfer();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (8) @(negedge CLK);
  endtask

  task automatic send(input int nbits, input logic [1:0] flip2, input logic flip_all);
    for (int b = 0; b < nbits; b++) begin
      int w;
      int s;
      w = b / 13;
      s = b % 13;
      ENABLE_XFR = 1'b1;
      if (s < 12) begin
        SERIAL_IN0 = l0[w][11-s];
        SERIAL_IN1 = l1[w][11-s];
      end else begin
        SERIAL_IN0 = p0[w] ^ flip_all ^ ((w == 2) & flip2[0]);
        SERIAL_IN1 = p1[w] ^ flip_all ^ ((w == 2) & flip2[1]);
      end
      @(negedge CLK);
    end
    ENABLE_XFR = 1'b0;
    SERIAL_IN0 = 1'b0;
    SERIAL_IN1 = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int k;
    k = 0;
    while (n_done == base && k < 300) begin
      @(negedge CLK);
      k++;
    end
    repeat (5) @(negedge CLK);
  endtask

  task automatic check_words(input string tg, input int b, input int nexp,
                             input logic [1:0] ep2, input logic [1:0] eoth);
    chk($sformatf("%s_nwr", tg), n_wr - b, nexp);
    for (int i = 0; i < nexp; i++) begin
      chk($sformatf("%s_addr%0d", tg, i), m_addr[b+i], i);
      chk($sformatf("%s_d0_%0d", tg, i), m_d0[b+i], l0[i]);
      chk($sformatf("%s_d1_%0d", tg, i), m_d1[b+i], l1[i]);
      chk($sformatf("%s_perr%0d", tg, i), m_perr[b+i], (i == 2) ? ep2 : eoth);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int wb, db, hi, n, k;
    RESET = 1'b1; START = 1'b0; CLR_ERR = 1'b0;
    ENABLE_XFR = 1'b0; SERIAL_IN0 = 1'b0; SERIAL_IN1 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_trigger", TRIGGER, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_wr_en", WR_EN, 0);
    chk("rst_done", DONE, 0);
    chk("rst_word_count", WORD_COUNT, 0);
    chk("rst_perr_count", PERR_COUNT, 0);
    chk("rst_errs", {ERR_TIMEOUT, ERR_SHORT}, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Clean full transfer
    wb = n_wr; db = n_done;
    start_xfer();
    send(13 * NW, 2'b00, 1'b0);
    wait_done(db);
    check_words("clean", wb, NW, 2'b00, 2'b00);
    chk("clean_word_count", WORD_COUNT, NW);
    chk("clean_done_cnt", n_done - db, 1);
    chk("clean_errs", {ERR_TIMEOUT, ERR_SHORT}, 0);
    chk("clean_perr_count", PERR_COUNT, 0);
    chk("clean_busy", BUSY, 0);

    // Lane 1 parity flipped on word 2
    wb = n_wr; db = n_done;
    start_xfer();
    send(13 * NW, 2'b10, 1'b0);
    wait_done(db);
    check_words("perr", wb, NW, PCHK ? 2'b10 : 2'b00, 2'b00);
    chk("perr_count", PERR_COUNT, PCHK ? 1 : 0);
    chk("perr_done_cnt", n_done - db, 1);

    // Timeout: no ENABLE_XFR
    wb = n_wr; db = n_done;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    hi = 0; k = 0;
    while (TRIGGER === 1'b1 && k < 50) begin
      hi++;
      @(negedge CLK);
      k++;
    end
    chk("to_trigger_width", hi, TW);
    n = 0;
    while (DONE !== 1'b1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("to_done_latency", n, TO);
    chk("to_err_timeout", ERR_TIMEOUT, 1);
    repeat (5) @(negedge CLK);
    chk("to_no_write", n_wr - wb, 0);
    chk("to_done_cnt", n_done - db, 1);

    // Short transfer: one word plus 5 bits
    wb = n_wr; db = n_done;
    start_xfer();
    send(13 + 5, 2'b00, 1'b0);
    wait_done(db);
    check_words("short", wb, 1, 2'b00, 2'b00);
    chk("short_word_count", WORD_COUNT, 1);
    chk("short_err_short", ERR_SHORT, 1);
    chk("short_done_cnt", n_done - db, 1);
    @(negedge CLK); CLR_ERR = 1'b1;
    @(negedge CLK); CLR_ERR = 1'b0;
    @(negedge CLK);
    chk("clr_err_short", ERR_SHORT, 0);
    chk("clr_err_timeout", ERR_TIMEOUT, 0);
    chk("clr_perr_count", PERR_COUNT, 0);

    // Reset during word 2
    wb = n_wr; db = n_done;
    start_xfer();
    fork
      send(13 * NW, 2'b00, 1'b0);
      begin
        k = 0;
        while (n_wr - wb < 2 && k < 300) begin
          @(negedge CLK);
          k++;
        end
        repeat (4) @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_word_count", WORD_COUNT, 0);
        chk("mid_rst_wr_data0", WR_DATA0, 0);
        chk("mid_rst_wr_en", WR_EN, 0);
        chk("mid_rst_done", DONE, 0);
        @(negedge CLK);
        RESET = 1'b0;
      end
    join
    repeat (10) @(negedge CLK);
    chk("mid_rst_writes", n_wr - wb, 2);
    chk("mid_rst_no_done", n_done - db, 0);

    wb = n_wr; db = n_done;
    start_xfer();
    send(13 * NW, 2'b00, 1'b0);
    wait_done(db);
    check_words("after_rst", wb, NW, 2'b00, 2'b00);
    chk("after_rst_word_count", WORD_COUNT, NW);
    chk("after_rst_done_cnt", n_done - db, 1);

    // Every parity bit corrupted on both lanes
    wb = n_wr; db = n_done;
    start_xfer();
    send(13 * NW, 2'b00, 1'b1);
    wait_done(db);
    check_words("bad_par", wb, NW, PCHK ? 2'b11 : 2'b00, PCHK ? 2'b11 : 2'b00);
    chk("bad_par_count", PERR_COUNT, PCHK ? NW : 0);
    chk("bad_par_errs", {ERR_TIMEOUT, ERR_SHORT}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
